// File: rtl/ir_fetch.sv
// rtl/ir_fetch.sv - instruction fetch stage: PC, memory req/ack fetch, IR and uPC map strobe
// Optional macro FETCH_TIMEOUT_EN adds an abort-on-timeout REQ counter and sticky fetch_err.
module ir_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_req,
  input  logic       pc_ld,
  input  logic [7:0] pc_in,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [7:0] ir_out,
  output logic [3:0] map_addr,
  output logic       map_valid,
  output logic       busy,
  output logic       fetch_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    MAP    = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t     state, state_next;
  logic [7:0] pc, pc_next;
  logic [7:0] ir, ir_next;
  logic       timed_out;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("ir_fetch: TIMEOUT must be in 1..255");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       err;

  // Counter sits at zero outside REQ, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'h00;
      err      <= 1'b0;
    end else begin
      if (state != REQ)
        wait_cnt <= 8'h00;
      else if (!mem_ack)
        wait_cnt <= wait_cnt + 8'd1;
      if (timed_out)
        err <= 1'b1;
    end
  end

  assign timed_out = (state == REQ) && !mem_ack && (wait_cnt == TIMEOUT_LAST);
  assign fetch_err = err;
`else
  assign timed_out = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= 8'h00;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    mem_rd     = 1'b0;
    map_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pc_ld)
          pc_next = pc_in;
        if (fetch_req)
          state_next = REQ;
      end
      REQ: begin
        mem_rd = 1'b1;
        // An ack arriving on the timeout edge still completes the fetch.
        if (mem_ack) begin
          ir_next    = mem_data;
          pc_next    = pc + 8'd1;
          state_next = MAP;
        end else if (timed_out) begin
          state_next = IDLE;
        end
      end
      MAP: begin
        map_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr = pc;
  assign ir_out   = ir;
  assign map_addr = ir[7:4];

endmodule

// File: tb/tb_ir_fetch.sv
// tb/tb_ir_fetch.sv - table-driven and directed-sequence bench for ir_fetch
module tb_ir_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req, pc_ld, mem_ack;
  logic [7:0] pc_in, mem_data;
  logic [7:0] mem_addr, ir_out;
  logic       mem_rd, map_valid, busy, fetch_err;
  logic [3:0] map_addr;

  int n_cmp = 0;
  int n_err = 0;

  ir_fetch #(.RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_ld(pc_ld), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .ir_out(ir_out), .map_addr(map_addr), .map_valid(map_valid), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       fetch_req;
    logic       pc_ld;
    logic [7:0] pc_in;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] exp_addr;
    logic       exp_rd;
    logic [7:0] exp_ir;
    logic [3:0] exp_map;
    logic       exp_mv;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic fr, input logic ld, input logic [7:0] pi,
                     input logic ack, input logic [7:0] md, input logic [7:0] ea,
                     input logic erd, input logic [7:0] eir, input logic [3:0] emap,
                     input logic emv, input logic ebusy);
    vec_t v;
    v.name = n; v.fetch_req = fr; v.pc_ld = ld; v.pc_in = pi; v.mem_ack = ack;
    v.mem_data = md; v.exp_addr = ea; v.exp_rd = erd; v.exp_ir = eir;
    v.exp_map = emap; v.exp_mv = emv; v.exp_busy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] data);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ack   = 1'b1;
    mem_data  = data;
    step();
    mem_ack   = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cycles;
    int mv_count;
    logic ir_moved;

    rst = 1'b0; fetch_req = 1'b0; pc_ld = 1'b0; pc_in = 8'h00;
    mem_ack = 1'b0; mem_data = 8'h00;

    //  name          fr ld pc_in ack data   addr  rd ir     map  mv busy
    add("idle",       0, 0, 8'h00, 1, 8'h3A, 8'h00, 0, 8'h00, 4'h0, 0, 0);
    add("req0",       1, 0, 8'h00, 1, 8'h3A, 8'h00, 1, 8'h00, 4'h0, 0, 1);
    add("map3A",      0, 0, 8'h00, 1, 8'h3A, 8'h01, 0, 8'h3A, 4'h3, 1, 1);
    add("back_idle",  0, 0, 8'h00, 1, 8'h3A, 8'h01, 0, 8'h3A, 4'h3, 0, 0);
    add("pc_ld_ff",   0, 1, 8'hFF, 0, 8'h00, 8'hFF, 0, 8'h3A, 4'h3, 0, 0);
    add("req_ff",     1, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 8'h3A, 4'h3, 0, 1);
    add("wrap_map",   0, 0, 8'h00, 1, 8'hC7, 8'h00, 0, 8'hC7, 4'hC, 1, 1);
    add("ign_in_map", 1, 1, 8'h55, 0, 8'h00, 8'h00, 0, 8'hC7, 4'hC, 0, 0);
    add("ld_and_req", 1, 1, 8'h10, 0, 8'h00, 8'h10, 1, 8'hC7, 4'hC, 0, 1);
    add("ign_in_req", 1, 1, 8'h55, 0, 8'h00, 8'h10, 1, 8'hC7, 4'hC, 0, 1);
    add("ack_w_junk", 1, 1, 8'h55, 1, 8'h9E, 8'h11, 0, 8'h9E, 4'h9, 1, 1);
    add("idle_11",    0, 0, 8'h00, 0, 8'h00, 8'h11, 0, 8'h9E, 4'h9, 0, 0);

    #12;
    check("reset_state", {mem_addr, mem_rd, ir_out, map_addr, map_valid, busy, fetch_err},
          {8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      fetch_req = vecs[i].fetch_req;
      pc_ld     = vecs[i].pc_ld;
      pc_in     = vecs[i].pc_in;
      mem_ack   = vecs[i].mem_ack;
      mem_data  = vecs[i].mem_data;
      step();
      check(vecs[i].name, {mem_addr, mem_rd, ir_out, map_addr, map_valid, busy},
            {vecs[i].exp_addr, vecs[i].exp_rd, vecs[i].exp_ir, vecs[i].exp_map,
             vecs[i].exp_mv, vecs[i].exp_busy});
    end
    fetch_req = 1'b0; pc_ld = 1'b0; mem_ack = 1'b0;

    // Ack delayed to the fifth REQ cycle.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    rd_cycles = 0;
    ir_moved  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      mem_ack  = (k == 5);
      mem_data = 8'h6B;
      if (mem_rd && busy) rd_cycles++;
      if (ir_out != 8'h9E) ir_moved = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check("slow_rd_cycles", rd_cycles, 5);
    check("slow_ir_held", ir_moved, 0);
    check("slow_map", {mem_addr, mem_rd, ir_out, map_addr, map_valid}, {8'h12, 1'b0, 8'h6B, 4'h6, 1'b1});
    mv_count = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (map_valid) mv_count++;
    end
    check("slow_single_pulse", mv_count, 0);

    // Asynchronous reset in the middle of REQ.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("pre_rst_req", {mem_rd, busy}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_req", {mem_rd, busy, ir_out, mem_addr, map_valid}, {1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
    mem_ack = 1'b1; mem_data = 8'hAA;
    @(negedge clk);
    rst = 1'b1;
    mv_count = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (map_valid || mem_rd) mv_count++;
    end
    mem_ack = 1'b0;
    check("late_ack_ignored", {ir_out, mem_addr, busy}, {8'h00, 8'h00, 1'b0});
    check("late_ack_no_activity", mv_count, 0);

    do_fetch(8'h5D);
    check("post_rst_fetch", {ir_out, mem_addr, fetch_err}, {8'h5D, 8'h01, 1'b0});

`ifdef FETCH_TIMEOUT_EN
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    rd_cycles = 0;
    mv_count  = 0;
    while (mem_rd && rd_cycles < 40) begin
      rd_cycles++;
      step();
      if (map_valid) mv_count++;
    end
    check("to_rd_cycles", rd_cycles, 15);
    check("to_abort", {fetch_err, busy, ir_out, mem_addr}, {1'b1, 1'b0, 8'h5D, 8'h01});
    check("to_no_map", mv_count, 0);

    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      mem_ack  = (k == 15);
      mem_data = 8'hE2;
      step();
    end
    mem_ack = 1'b0;
    check("to_ack_wins", {map_valid, ir_out, mem_addr, fetch_err}, {1'b1, 8'hE2, 8'h02, 1'b1});
    step();
    do_fetch(8'h11);
    check("to_sticky", {fetch_err, ir_out}, {1'b1, 8'h11});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("to_err_cleared", fetch_err, 0);
    @(negedge clk);
    rst = 1'b1;
`else
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check("no_to_still_req", {mem_rd, busy, fetch_err}, {1'b1, 1'b1, 1'b0});
    mem_ack = 1'b1; mem_data = 8'h47;
    step();
    mem_ack = 1'b0;
    check("no_to_complete", {map_valid, ir_out, mem_addr, fetch_err}, {1'b1, 8'h47, 8'h02, 1'b0});
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ir_fetch.md
Name: ir_fetch

Overview:
- Instruction fetch stage directly upstream of the microprogram address generator (w_uPC).
- Holds the program counter and fetches one instruction byte per request from main memory over a req/ack handshake, then latches it into IR.
- Presents IR[7:4] as a 4-bit microprogram entry address on map_addr, strobed by map_valid, for the uPC's in_pc input.
- Fetches are started by the microcode fetch cycle (fetch_req).

Parameters:
- RESET_PC, 8'h00, PC value after reset.
- TIMEOUT, 15, cycles REQ waits for mem_ack before abort (only with FETCH_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- fetch_req  input  1  start a fetch; sampled only in IDLE
- pc_ld  input  1  load PC from pc_in; honoured only in IDLE
- pc_in  input  8  jump target (from dbus)
- mem_addr  output  8  memory address; equals PC
- mem_rd  output  1  read request, high for the whole of REQ
- mem_ack  input  1  memory data valid; sampled only in REQ
- mem_data  input  8  instruction byte, valid when mem_ack=1
- ir_out  output  8  instruction register
- map_addr  output  4  microprogram entry address = ir_out[7:4]
- map_valid  output  1  one-cycle strobe: map_addr is fresh
- busy  output  1  high in any state other than IDLE
- fetch_err  output  1  sticky timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, asynchronous, regardless of clk):
  - state=IDLE, PC=RESET_PC, IR=8'h00.
  - mem_rd=0, map_valid=0, busy=0, fetch_err=0, timeout counter=0.
  - A reset mid-fetch abandons the fetch without writing IR; mem_rd drops immediately.
- States: IDLE, REQ, MAP. The state register is 2-bit; the unused encoding returns to IDLE on the next edge.
- IDLE:
  - If pc_ld=1: PC<=pc_in.
  - If fetch_req=1: go to REQ.
  - If both are high: PC<=pc_in this edge and the fetch goes to REQ, so the next fetch uses the new PC.
- REQ:
  - mem_rd=1, mem_addr=PC, busy=1.
  - Stays in REQ while mem_ack=0.
  - On the edge where mem_ack=1: IR<=mem_data, PC<=PC+1 (modulo 256, so 8'hFF wraps to 8'h00), go to MAP.
  - Minimum fetch latency: fetch_req sampled at edge N, mem_ack high at edge N+1, map_valid high during cycle N+1..N+2.
- MAP:
  - map_valid=1 for exactly one cycle; map_addr=IR[7:4]; busy=1.
  - Unconditionally returns to IDLE.
- fetch_req and pc_ld are ignored outside IDLE; they are not queued.
- mem_ack outside REQ is ignored.
- mem_addr always reflects PC combinationally.
- map_addr is continuously IR[7:4]; consumers use it only when map_valid=1.
- map_valid and mem_rd are decoded from registered state and are glitch-free relative to clk.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entering REQ and increments each REQ cycle without mem_ack.
  - When it reaches TIMEOUT with mem_ack still 0, the fetch aborts: IR and PC are unchanged, fetch_err<=1 (sticky until reset), state goes to IDLE, and no map_valid pulse is issued.
  - mem_ack on the same edge as the count reaching TIMEOUT wins: the fetch completes normally.
- When undefined: REQ waits indefinitely, no counter is built, and fetch_err is constant 0.

Test Plan:
- Reset with RESET_PC=0, mem_data=8'h3A, mem_ack held high; pulse fetch_req -> mem_rd high 1 cycle at mem_addr=0, then ir_out=8'h3A, map_addr=4'h3, map_valid high one cycle, PC=1.
- mem_ack delayed 5 cycles -> mem_rd and busy stay high 5 cycles; IR loads on the ack edge only; exactly one map_valid pulse follows.
- pc_ld=1 with pc_in=8'hFF in IDLE, then fetch -> mem_addr=8'hFF, PC wraps to 8'h00; a second fetch uses address 0.
- fetch_req and pc_ld (pc_in=8'h55) pulsed during REQ and MAP -> both ignored; PC increments normally and no second fetch starts.
- rst asserted mid-REQ with ack pending -> mem_rd=0 and busy=0 immediately; IR=0, PC=RESET_PC; a later ack has no effect.
- FETCH_TIMEOUT_EN, TIMEOUT=15, mem_ack never asserted -> after 15 REQ cycles: return to IDLE, fetch_err=1, IR and PC unchanged, no map_valid; fetch_err stays 1 across further good fetches until reset.
